// File: rtl/mux_nx1_rr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_nx1_rr_pkg : shared mode encodings and select-width helper             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package mux_nx1_rr_pkg;

    localparam logic MODE_EXPLICIT = 1'b0;
    localparam logic MODE_RR       = 1'b1;

    // Index width for n channels; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_nx1_rr_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_nx1_rr_if : channel-side and consumer-side handshake bundle            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface mux_nx1_rr_if
    import mux_nx1_rr_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = sel_width(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    // The mux itself sits on the slave side.
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

endinterface
`default_nettype wire

// File: rtl/mux_nx1_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter : combinational explicit-select / round-robin grant logic       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rr_arbiter
    import mux_nx1_rr_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [SEL_W-1:0]    ptr_i,
    input  logic                mode_i,
    input  logic [SEL_W-1:0]    sel_i,
    output logic [CHANNELS-1:0] gnt_oh_o,
    output logic [SEL_W-1:0]    gnt_idx_o,
    output logic                gnt_valid_o
);

    logic [2*CHANNELS-1:0] w_req2;
    logic [2*CHANNELS-1:0] w_rot;
    logic [CHANNELS-1:0]   w_sel_oh;

    // Doubling the request vector turns the wrap-around search into a plain
    // lowest-set-bit search on a right-shifted copy.
    assign w_req2   = {req_i, req_i};
    assign w_rot    = w_req2 >> ptr_i;
    // An out-of-range select shifts the single bit off the top: no grant.
    assign w_sel_oh = CHANNELS'(1) << sel_i;

    always_comb begin
        int w_off;
        int w_sum;
        gnt_oh_o    = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        w_off       = 0;
        w_sum       = 0;
        if (mode_i == MODE_EXPLICIT) begin
            gnt_oh_o    = req_i & w_sel_oh;
            gnt_valid_o = |gnt_oh_o;
            gnt_idx_o   = sel_i;
        end else begin
            for (int j = CHANNELS - 1; j >= 0; j--) begin
                if (w_rot[j]) begin
                    w_off = j;
                end
            end
            gnt_valid_o = |w_rot[CHANNELS-1:0];
            w_sum       = int'(ptr_i) + w_off;
            if (w_sum >= CHANNELS) begin
                w_sum = w_sum - CHANNELS;
            end
            if (gnt_valid_o) begin
                gnt_idx_o = SEL_W'(w_sum);
                gnt_oh_o  = CHANNELS'(1) << w_sum;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_nx1_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_nx1_rr : registered N-to-1 mux, explicit or round-robin selection      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mux_nx1_rr
    import mux_nx1_rr_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    mux_nx1_rr_if.slave bus
);

    localparam int SEL_W = sel_width(CHANNELS);

    logic [CHANNELS-1:0] w_gnt_oh;
    logic [SEL_W-1:0]    w_gnt_idx;
    logic                w_gnt_valid;
    logic                w_load_en;
    logic [WIDTH-1:0]    w_word;

    logic [WIDTH-1:0]    data_d,  data_q;
    logic [SEL_W-1:0]    chan_d,  chan_q;
    logic                valid_d, valid_q;
    logic [SEL_W-1:0]    ptr_d,   ptr_q;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_arb (
        .req_i       (bus.in_valid),
        .ptr_i       (ptr_q),
        .mode_i      (bus.mode),
        .sel_i       (bus.sel),
        .gnt_oh_o    (w_gnt_oh),
        .gnt_idx_o   (w_gnt_idx),
        .gnt_valid_o (w_gnt_valid)
    );

    // Single slot: it may be refilled in the same cycle it drains.
    assign w_load_en    = !valid_q || bus.out_ready;
    assign bus.in_ready = (rst_n && w_load_en && w_gnt_valid) ? w_gnt_oh : '0;

    always_comb begin
        w_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_gnt_oh[i]) begin
                w_word = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (w_load_en) begin
            if (w_gnt_valid) begin
                data_d  = w_word;
                chan_d  = w_gnt_idx;
                valid_d = 1'b1;
                if (bus.mode == MODE_RR) begin
                    ptr_d = (w_gnt_idx == SEL_W'(CHANNELS - 1)) ? '0
                                                                : w_gnt_idx + SEL_W'(1);
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
    assign bus.out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_nx1_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mux_nx1_rr : scoreboard bench for a 4-channel and a 3-channel mux       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mux_nx1_rr;
    import mux_nx1_rr_pkg::*;

    localparam int W = 8;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_nx1_rr_if #(.WIDTH(W), .CHANNELS(C)) bus4 ();
    mux_nx1_rr_if #(.WIDTH(W), .CHANNELS(3)) bus3 ();

    mux_nx1_rr #(.WIDTH(W), .CHANNELS(C)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    mux_nx1_rr #(.WIDTH(W), .CHANNELS(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] chan;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    logic       m_valid;
    logic [1:0] m_ptr;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic void model_grant(input logic [3:0] req, input logic md,
                                        input logic [1:0] s, input logic [1:0] ptr,
                                        output logic gv, output logic [1:0] g);
        gv = 1'b0;
        g  = 2'd0;
        if (md == MODE_EXPLICIT) begin
            if (req[s]) begin
                gv = 1'b1;
                g  = s;
            end
        end else begin
            for (int k = 0; k < C; k++) begin
                int c;
                c = (int'(ptr) + k) % C;
                if (!gv && req[c]) begin
                    gv = 1'b1;
                    g  = c[1:0];
                end
            end
        end
    endfunction

    // One clock of the 4-channel instance: check handshake and drain at the
    // negedge, then advance the model across the posedge.
    task automatic tick(input string tag);
        logic       gv;
        logic [1:0] g;
        logic       le;
        logic [3:0] exp_rdy;
        exp_t       e;
        @(negedge clk);
        model_grant(bus4.in_valid, bus4.mode, bus4.sel, m_ptr, gv, g);
        le      = !m_valid || bus4.out_ready;
        exp_rdy = (le && gv) ? (4'b0001 << g) : 4'b0000;
        check_eq({tag, " in_ready"}, bus4.in_ready, exp_rdy);
        check_eq({tag, " out_valid"}, bus4.out_valid, m_valid);
        if (bus4.out_valid && bus4.out_ready) begin
            if (sb.size() == 0) begin
                check_eq({tag, " unexpected word"}, 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq({tag, " sb chan"}, bus4.out_chan, e.chan);
                check_eq({tag, " sb data"}, bus4.out_data, e.data);
            end
        end
        @(posedge clk);
        if (le) begin
            if (gv) begin
                m_valid = 1'b1;
                sb.push_back('{chan: g, data: bus4.in_data[g*8 +: 8]});
                if (bus4.mode == MODE_RR) m_ptr = (g == 2'd3) ? 2'd0 : g + 2'd1;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        int rr_seq[5];
        int sp_seq[3];
        int c3_seq[4];
        logic [7:0] c3_dat[3];
        rr_seq = '{0, 1, 2, 3, 0};
        sp_seq = '{3, 1, 3};
        c3_seq = '{0, 1, 2, 0};
        c3_dat = '{8'hA0, 8'hB1, 8'hC2};

        rst_n          = 1'b0;
        bus4.in_data   = '0;
        bus4.in_valid  = 4'hF;
        bus4.mode      = MODE_RR;
        bus4.sel       = '0;
        bus4.out_ready = 1'b1;
        bus3.in_data   = '0;
        bus3.in_valid  = '0;
        bus3.mode      = MODE_EXPLICIT;
        bus3.sel       = '0;
        bus3.out_ready = 1'b1;
        m_valid        = 1'b0;
        m_ptr          = 2'd0;

        #12;
        check_eq("reset out_valid", bus4.out_valid, 0);
        check_eq("reset out_data", bus4.out_data, 0);
        check_eq("reset out_chan", bus4.out_chan, 0);
        check_eq("reset in_ready", bus4.in_ready, 0);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus4.in_valid = 4'h0;

        // Explicit select of channel 2.
        bus4.in_data  = {8'h33, 8'hA5, 8'h22, 8'h11};
        bus4.in_valid = 4'b0100;
        bus4.mode     = MODE_EXPLICIT;
        bus4.sel      = 2'd2;
        #1;
        check_eq("m0 in_ready sel2", bus4.in_ready, 4'b0100);
        tick("m0 sel2");
        check_eq("m0 out_data", bus4.out_data, 8'hA5);
        check_eq("m0 out_chan", bus4.out_chan, 2);
        bus4.sel = 2'd1;
        tick("m0 sel1 idle");
        check_eq("m0 drained valid", bus4.out_valid, 0);
        check_eq("m0 data hold", bus4.out_data, 8'hA5);

        // Round-robin, all channels requesting.
        bus4.in_data  = {8'h43, 8'h32, 8'h21, 8'h10};
        bus4.in_valid = 4'hF;
        bus4.mode     = MODE_RR;
        for (int k = 0; k < 5; k++) begin
            tick("rr all");
            check_eq("rr seq chan", bus4.out_chan, rr_seq[k]);
        end

        // Move the pointer to 2, then only channels 1 and 3 request.
        bus4.in_valid = 4'b0010;
        tick("sparse prep");
        bus4.in_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            tick("sparse");
            check_eq("sparse chan", bus4.out_chan, sp_seq[k]);
        end

        // Backpressure stall with a word held.
        bus4.in_valid  = 4'hF;
        bus4.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick("stall");
            check_eq("stall data", bus4.out_data, 8'h43);
            check_eq("stall in_ready", bus4.in_ready, 0);
        end
        bus4.out_ready = 1'b1;
        tick("stall release");
        check_eq("release chan", bus4.out_chan, 0);
        check_eq("release data", bus4.out_data, 8'h10);

        // Mode switch must leave the pointer alone.
        bus4.mode = MODE_EXPLICIT;
        bus4.sel  = 2'd3;
        tick("switch m0");
        check_eq("switch m0 chan", bus4.out_chan, 3);
        bus4.mode = MODE_RR;
        tick("switch rr");
        check_eq("switch rr chan", bus4.out_chan, 1);

        for (int k = 0; k < 300; k++) begin
            bus4.in_data   = $urandom();
            bus4.in_valid  = 4'($urandom_range(0, 15));
            bus4.mode      = 1'($urandom_range(0, 1));
            bus4.sel       = 2'($urandom_range(0, 3));
            bus4.out_ready = ($urandom_range(0, 3) != 0);
            tick("random");
        end

        // Asynchronous reset with a word held.
        bus4.in_valid  = 4'hF;
        bus4.mode      = MODE_RR;
        bus4.out_ready = 1'b0;
        tick("pre reset");
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async rst out_valid", bus4.out_valid, 0);
        check_eq("async rst out_data", bus4.out_data, 0);
        check_eq("async rst out_chan", bus4.out_chan, 0);
        check_eq("async rst in_ready", bus4.in_ready, 0);
        m_valid = 1'b0;
        m_ptr   = 2'd0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        bus4.in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
        bus4.out_ready = 1'b1;
        tick("post reset");
        check_eq("post reset chan", bus4.out_chan, 0);
        check_eq("post reset valid", bus4.out_valid, 1);

        bus4.in_valid = 4'h0;
        tick("drain");
        tick("drain");
        check_eq("sb empty", sb.size(), 0);

        // Three-channel instance: out-of-range select, then pointer wrap.
        bus3.in_data  = {c3_dat[2], c3_dat[1], c3_dat[0]};
        bus3.in_valid = 3'b111;
        bus3.mode     = MODE_EXPLICIT;
        bus3.sel      = 2'd3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("c3 sel3 in_ready", bus3.in_ready, 0);
            check_eq("c3 sel3 out_valid", bus3.out_valid, 0);
            @(posedge clk);
            #1;
        end
        bus3.mode = MODE_RR;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("c3 rr in_ready", bus3.in_ready, 3'b001 << c3_seq[k]);
            @(posedge clk);
            #1;
            check_eq("c3 rr chan", bus3.out_chan, c3_seq[k]);
            check_eq("c3 rr data", bus3.out_data, c3_dat[c3_seq[k]]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
